// File: rtl/spi_mem_ctrl_pkg.sv
// Shared types and constants for the SPI-to-memory command sequencer.
package spi_mem_ctrl_pkg;

  localparam int CMD_WIDTH = 2;
  localparam int ERR_WIDTH = 3;

  // Bit positions inside the sticky err vector
  localparam int ERR_OVF = 0;
  localparam int ERR_SEQ = 1;
  localparam int ERR_TMO = 2;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MEM_WR  = 3'd1,
    MEM_RD  = 3'd2,
    RD_WAIT = 3'd3,
    TX      = 3'd4
  } mem_ctrl_state_e;

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// Bus bundle between the sequencer, the SPI slave and the shared memory port.
interface spi_mem_ctrl_if
  import spi_mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  logic [CMD_WIDTH+ADDR_WIDTH-1:0] rx_data;
  logic                            rx_valid;
  logic [DATA_WIDTH-1:0]           tx_data;
  logic                            tx_valid;
  logic                            mem_req;
  logic                            mem_we;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic                            mem_gnt;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  logic                            mem_rvalid;
  logic                            busy;
  logic [ERR_WIDTH-1:0]            err;
  logic                            err_clr;

  // The sequencer side: it masters the memory port
  modport master (
    input  rx_data, rx_valid, mem_gnt, mem_rdata, mem_rvalid, err_clr,
    output tx_data, tx_valid, mem_req, mem_we, mem_addr, mem_wdata, busy, err
  );

  // The environment side: SPI slave, memory arbiter and status reader
  modport slave (
    output rx_data, rx_valid, mem_gnt, mem_rdata, mem_rvalid, err_clr,
    input  tx_data, tx_valid, mem_req, mem_we, mem_addr, mem_wdata, busy, err
  );

endinterface

// File: rtl/spi_mem_ctrl_frame_buf.sv
// One-entry frame buffer between the SPI slave and the command FSM.
// A push into a full buffer that is not being popped is dropped and flagged.
module spi_mem_ctrl_frame_buf #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             ovf
);

  logic             buf_vld_q, buf_vld_d;
  logic [WIDTH-1:0] buf_data_q, buf_data_d;

  // Next-state: load when empty or freed this cycle, otherwise drain on pop
  always_comb begin
    buf_vld_d  = buf_vld_q;
    buf_data_d = buf_data_q;
    ovf        = 1'b0;
    if (push && (!buf_vld_q || pop)) begin
      buf_vld_d  = 1'b1;
      buf_data_d = push_data;
    end else begin
      if (pop) begin
        buf_vld_d = 1'b0;
      end
      if (push) begin
        ovf = 1'b1;
      end
    end
  end

  // Buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld_q  <= 1'b0;
      buf_data_q <= '0;
    end else begin
      buf_vld_q  <= buf_vld_d;
      buf_data_q <= buf_data_d;
    end
  end

  assign full = buf_vld_q;
  assign data = buf_data_q;

endmodule

// File: rtl/spi_mem_ctrl.sv
// Command sequencer: decodes SPI frames, keeps the write/read address
// registers and runs single memory accesses over a shared req/gnt port.
// All bus outputs are registered so they stay stable while waiting for gnt.
module spi_mem_ctrl
  import spi_mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          rst,
  spi_mem_ctrl_if.master bus
);

  localparam int FRAME_WIDTH = CMD_WIDTH + ADDR_WIDTH;
  localparam int CNT_WIDTH   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  mem_ctrl_state_e       state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_addr_vld_q, rd_addr_vld_d;
  logic [CNT_WIDTH-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;

  logic                   buf_full;
  logic                   buf_pop;
  logic                   buf_ovf;
  logic [FRAME_WIDTH-1:0] buf_data;
  spi_cmd_e               cmd;
  logic [ADDR_WIDTH-1:0]  payload;
  logic                   seq_evt;
  logic                   tmo_evt;

  spi_mem_ctrl_frame_buf #(
    .WIDTH(FRAME_WIDTH)
  ) u_frame_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.rx_valid),
    .push_data(bus.rx_data),
    .pop      (buf_pop),
    .full     (buf_full),
    .data     (buf_data),
    .ovf      (buf_ovf)
  );

  assign cmd     = spi_cmd_e'(buf_data[FRAME_WIDTH-1:ADDR_WIDTH]);
  assign payload = buf_data[ADDR_WIDTH-1:0];

  // Next-state and output decode; every access ends on gnt/rvalid or timeout
  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    rd_addr_vld_d = rd_addr_vld_q;
    tmo_cnt_d     = tmo_cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = 1'b0;
    buf_pop       = 1'b0;
    seq_evt       = 1'b0;
    tmo_evt       = 1'b0;

    case (state_q)
      IDLE: begin
        if (buf_full) begin
          buf_pop = 1'b1;
          case (cmd)
            WR_ADDR: wr_addr_d = payload;
            RD_ADDR: begin
              rd_addr_d     = payload;
              rd_addr_vld_d = 1'b1;
            end
            WR_DATA: begin
              state_d     = MEM_WR;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = wr_addr_q;
              mem_wdata_d = DATA_WIDTH'(payload);
              tmo_cnt_d   = '0;
            end
            RD_DATA: begin
              if (rd_addr_vld_q) begin
                state_d    = MEM_RD;
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = rd_addr_q;
                tmo_cnt_d  = '0;
              end else begin
                seq_evt = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      MEM_WR: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else if (tmo_cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          tmo_evt   = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      MEM_RD: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          tmo_cnt_d = '0;
          state_d   = RD_WAIT;
        end else if (tmo_cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          tmo_evt   = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      RD_WAIT: begin
        if (bus.mem_rvalid) begin
          tx_data_d  = bus.mem_rdata;
          tx_valid_d = 1'b1;
          state_d    = TX;
        end else if (tmo_cnt_q == CNT_LAST) begin
          tmo_evt = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      TX: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    err_d = bus.err_clr ? '0 : err_q;
    if (buf_ovf) err_d[ERR_OVF] = 1'b1;
    if (seq_evt) err_d[ERR_SEQ] = 1'b1;
    if (tmo_evt) err_d[ERR_TMO] = 1'b1;
  end

  // Sequencer registers; reset drops any access in flight immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      rd_addr_vld_q <= 1'b0;
      tmo_cnt_q     <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      rd_addr_vld_q <= rd_addr_vld_d;
      tmo_cnt_q     <= tmo_cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      err_q         <= err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != IDLE) || buf_full;

endmodule
